// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. It computes diff = a - b one bit per clock,
// starting with the LSB. Each bit step is a full subtract: the two operand bits
// and a registered borrow produce one difference bit and the next borrow. A
// single sequencer FSM (IDLE -> RUN -> DONE) provides the start/done handshake.
//
// Ports
//   clk     in   1      single clock; all state updates on the rising edge
//   rst     in   1      synchronous, active-high reset
//   start   in   1      operation request; sampled only in IDLE or DONE
//   a       in   WIDTH  minuend, captured when start is accepted
//   b       in   WIDTH  subtrahend, captured when start is accepted
//   busy    out  1      high while the FSM is in RUN
//   done    out  1      one-cycle pulse; diff/borrow hold a new result
//   diff    out  WIDTH  (a - b) modulo 2**WIDTH
//   borrow  out  1      final borrow out, 1 when a < b (unsigned)
//
// Timing: start accepted at edge k, RUN occupies edges k+1..k+WIDTH, done is
// high in the cycle after edge k+WIDTH. One operation per WIDTH+1 cycles.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_reg;

    // Operand shift registers: bit 0 is the bit being processed this cycle.
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    // Difference bits enter at the MSB and move right, so after WIDTH shifts
    // the first (LSB) result bit has reached bit 0.
    logic [WIDTH-1:0] work_reg;
    logic             br_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Registered outputs.
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             busy_reg;
    logic             done_reg;

    // -------------------------------------------------------------------------
    // Single bit step
    // -------------------------------------------------------------------------
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] work_next;
    logic             last_bit;
    logic             accept;

    always_comb begin
        a_bit     = a_sh_reg[0];
        b_bit     = b_sh_reg[0];
        d_bit     = a_bit ^ b_bit ^ br_reg;
        // Borrow out when a<b for this bit, or when the bits are equal and a
        // borrow is already pending.
        br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);
        work_next = {d_bit, work_reg[WIDTH-1:1]};
        last_bit  = (cnt_reg == CNT_W'(WIDTH - 1));
        // start is only honoured when no operation is in flight.
        accept    = start && (state_reg != ST_RUN);
    end

    // -------------------------------------------------------------------------
    // Sequencer and datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            work_reg   <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            // done is a pulse; it is only re-asserted on the completing edge.
            done_reg <= 1'b0;

            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        work_reg  <= '0;
                        br_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_RUN;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    a_sh_reg <= a_sh_reg >> 1;
                    b_sh_reg <= b_sh_reg >> 1;
                    work_reg <= work_next;
                    br_reg   <= br_next;
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    if (last_bit) begin
                        // Publish the completed word directly from the step
                        // logic so the result lands on the same edge.
                        diff_reg   <= work_next;
                        borrow_reg <= br_next;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= ST_DONE;
                    end
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign diff   = diff_reg;
    assign borrow = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor (WIDTH=8). Expected {borrow, diff}
// values are computed from the operands when an operation is launched and
// queued; they are popped and compared when done is observed. Outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    int checks     = 0;
    int errors     = 0;
    int done_count = 0;

    // Each entry is {borrow, diff}.
    logic [WIDTH:0] exp_q[$];

    serial_subtractor #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    // Count done pulses as seen just before each rising edge.
    always @(posedge clk) begin
        if (done === 1'b1) done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge; presents operands with start for one cycle and
    // returns at the falling edge of RUN cycle 1.
    task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input bit push);
        logic [WIDTH-1:0] d;
        logic             br;
        d  = av - bv;
        br = (av < bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        if (push) exp_q.push_back({br, d});
        $display("op a=0x%02h b=0x%02h expect diff=0x%02h borrow=%0d queued=%0d",
                 av, bv, d, br, push);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts remaining busy cycles, then checks the done pulse and result.
    task automatic wait_done(input string tag, input int exp_busy);
        int             n;
        logic [WIDTH:0] e;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, n, exp_busy);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_diff"}, {24'd0, diff}, {24'd0, e[WIDTH-1:0]});
            check({tag, "_borrow"}, {31'd0, borrow}, {31'd0, e[WIDTH]});
            $display("done %s diff=0x%02h borrow=%0d", tag, diff, borrow);
        end
    endtask

    initial begin
        int dc;

        // 1. Reset and idle behaviour.
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done_count", done_count, 0);

        // 2. Basic subtraction.
        launch(8'h5A, 8'h23, 1'b1);
        wait_done("op_5a_23", WIDTH);
        @(negedge clk);
        check("op_5a_23_done_pulse", {31'd0, done}, 32'd0);

        // 3. Boundary operands.
        launch(8'h00, 8'h01, 1'b1);
        wait_done("op_00_01", WIDTH);
        @(negedge clk);
        launch(8'h80, 8'h80, 1'b1);
        wait_done("op_80_80", WIDTH);
        @(negedge clk);
        launch(8'hFF, 8'h00, 1'b1);
        wait_done("op_ff_00", WIDTH);
        @(negedge clk);
        check("after_ff_00_idle", {31'd0, busy}, 32'd0);

        // 4. start pulsed during RUN is ignored.
        dc = done_count;
        launch(8'h33, 8'h11, 1'b1);
        repeat (2) @(negedge clk);
        a     = 8'h11;
        b     = 8'h22;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start", WIDTH - 3);
        repeat (4) @(negedge clk);
        check("ignore_start_one_done", done_count - dc, 1);
        check("ignore_start_idle", {31'd0, busy}, 32'd0);

        // 5. Back-to-back: start held in DONE re-enters RUN directly.
        launch(8'h20, 8'h05, 1'b1);
        wait_done("b2b_first", WIDTH);
        launch(8'h10, 8'h01, 1'b1);
        check("b2b_no_idle_busy", {31'd0, busy}, 32'd1);
        check("b2b_no_idle_done", {31'd0, done}, 32'd0);
        check("b2b_diff_held_0", {24'd0, diff}, 32'h1B);
        repeat (3) @(negedge clk);
        check("b2b_diff_held_3", {24'd0, diff}, 32'h1B);
        wait_done("b2b_second", WIDTH - 3);
        @(negedge clk);

        // 6. Reset mid-RUN discards the operation.
        dc = done_count;
        launch(8'hFF, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_diff", {24'd0, diff}, 32'd0);
        check("midrst_borrow", {31'd0, borrow}, 32'd0);
        repeat (12) @(negedge clk);
        check("midrst_no_done", done_count - dc, 0);
        launch(8'h5A, 8'h23, 1'b1);
        wait_done("post_rst", WIDTH);
        @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (!rst && busy === 1'b1 && done === 1'b1) begin
            check("busy_done_overlap", 32'd1, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
